// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core types: opcode/function fields plus load/store unit size and state.
package mips_cpu_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SW      = 6'h2b
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25
  } funct_t;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Illegal size counts as misaligned so both reject paths share one flag.
  function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] addr_lo);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return addr_lo[0];
      WORD:    return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_lane.sv
// Byte-lane steering for the load/store unit: byte enables, store replication,
// load lane extraction with extension, and the misalignment flag.
module mips_cpu_lsu_lane
  import mips_cpu_pkg::*;
(
  input  lsu_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign misaligned = lsu_misaligned(size, addr_lo);
  assign rhalf      = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rbyte = rdata[7:0];
    case (addr_lo)
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      2'd3:    rbyte = rdata[31:24];
      default: rbyte = rdata[7:0];
    endcase
  end

  always_comb begin
    byteenable = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    case (size)
      BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        wdata_rep  = {4{wdata[7:0]}};
        rdata_ext  = {{24{is_signed & rbyte[7]}}, rbyte};
      end
      HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{is_signed & rhalf[15]}}, rhalf};
      end
      WORD: begin
        byteenable = 4'b1111;
      end
      default: begin
        byteenable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit bridging the execute stage to an Avalon-MM master port.
//   state | meaning
//   IDLE  | ready for a request; misaligned/illegal requests go straight to RESP
//   BUS   | Avalon read/write asserted, held while waitrequest (watchdog may abort)
//   RESP  | one-cycle resp_valid; load data sampled from readdata this cycle
module mips_cpu_lsu
  import mips_cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  lsu_state_t       state;
  lsu_size_t        size_l;
  logic             write_l;
  logic             signed_l;
  logic             err_l;
  logic [31:0]      addr_l;
  logic [31:0]      wdata_l;
  logic [CNT_W-1:0] wait_cnt;

  lsu_size_t        lane_size;
  logic [1:0]       lane_addr_lo;
  logic             lane_signed;
  logic [31:0]      lane_wdata_in;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_rdata;
  logic             lane_mis;
  logic             in_idle;
  logic             in_bus;
  logic             timeout;

  assign in_idle = (state == IDLE);
  assign in_bus  = (state == BUS);
  assign timeout = (WAIT_LIMIT > 0) && waitrequest && (wait_cnt == CNT_LAST);

  // In IDLE the lane logic looks at the incoming request to classify it;
  // afterwards it works from the latched copy.
  assign lane_size     = in_idle ? lsu_size_t'(req_size) : size_l;
  assign lane_addr_lo  = in_idle ? req_addr[1:0] : addr_l[1:0];
  assign lane_signed   = in_idle ? req_signed : signed_l;
  assign lane_wdata_in = in_idle ? req_wdata : wdata_l;

  mips_cpu_lsu_lane u_lane (
    .size       (lane_size),
    .addr_lo    (lane_addr_lo),
    .is_signed  (lane_signed),
    .wdata      (lane_wdata_in),
    .rdata      (readdata),
    .byteenable (lane_be),
    .wdata_rep  (lane_wdata),
    .rdata_ext  (lane_rdata),
    .misaligned (lane_mis)
  );

  assign req_ready  = in_idle && !reset;
  assign read       = in_bus && !write_l;
  assign write      = in_bus && write_l;
  assign address    = in_bus ? {addr_l[31:2], 2'b00} : 32'd0;
  assign writedata  = in_bus ? lane_wdata : 32'd0;
  assign byteenable = in_bus ? lane_be : 4'b0000;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_l;
  assign resp_rdata = (resp_valid && !err_l && !write_l) ? lane_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      size_l   <= BYTE;
      write_l  <= 1'b0;
      signed_l <= 1'b0;
      err_l    <= 1'b0;
      addr_l   <= 32'd0;
      wdata_l  <= 32'd0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_l   <= lsu_size_t'(req_size);
            write_l  <= req_write;
            signed_l <= req_signed;
            addr_l   <= req_addr;
            wdata_l  <= req_wdata;
            err_l    <= lane_mis;
            wait_cnt <= '0;
            state    <= lane_mis ? RESP : BUS;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            state <= RESP;
          end else if (timeout) begin
            err_l <= 1'b1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_cpu_lsu.md
# mips_cpu_lsu

Load/store unit between the MIPS core's execute stage and the Avalon memory-mapped bus master port. Accepts one byte/half/word load or store per request from the core, drives word-aligned Avalon transactions with correct byte lanes, honours `waitrequest`, and returns sign- or zero-extended load data. Misaligned or illegal-size requests are rejected without bus activity. An optional watchdog aborts stalled transactions.

## Interface
- `WAIT_LIMIT`, default 0: maximum consecutive `waitrequest` cycles before abort; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core request present.
- `req_ready` out 1: unit can accept; a request transfers when `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load result; ignored for word and for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; misaligned, illegal size or timeout.
- `address` out 32, `write` out 1, `read` out 1, `waitrequest` in 1, `writedata` out 32, `byteenable` out 4, `readdata` in 32: Avalon master.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: `req_ready`=1. On transfer, latch all `req_*` fields.
  - Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size 11. → RESP with error and no bus cycle.
  - Otherwise → BUS.
- BUS: `read`=!write_l, `write`=write_l, `address`={addr[31:2],2'b00}. All bus outputs are held stable while `waitrequest`=1. The cycle with `waitrequest`=0 accepts the transaction → RESP.
- Byte lanes are little-endian.
  - Byte: `byteenable`=1<<addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
- `writedata`: byte replicated ×4, half replicated ×2, word as-is.
- RESP (exactly one cycle): `resp_valid`=1.
  - Loads: `readdata` is sampled in this cycle (fixed read latency 1 after acceptance). The selected lane is shifted to bit 0 and extended per `req_signed`/size.
  - Stores and errors: `resp_rdata`=0.
  - Then → IDLE.
- Watchdog (WAIT_LIMIT>0): a counter increments each BUS cycle with `waitrequest`=1 and clears on entering BUS. On reaching WAIT_LIMIT, drop `read`/`write` next cycle and go to RESP with `resp_err`=1. Counter width is $clog2(WAIT_LIMIT+1).
- `read` and `write` are never both 1. `byteenable` is 0 outside BUS.

## Timing
- Reset values: state IDLE, `req_ready`=0 during the reset cycle and 1 afterwards. `read`=`write`=0, `address`=0, `writedata`=0, `byteenable`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
- Reset mid-BUS: `read`/`write` deassert on the next edge. No response is issued; the request is lost.
- Minimum latency with no wait states: transfer at edge 0, BUS during cycle 1, RESP during cycle 2. Error path: RESP during cycle 1.
- Each wait cycle adds one cycle of latency. Peak throughput is one request per 3 cycles (2 for errors).
- `req_ready`=0 in BUS and RESP. A request held by the core is accepted on the first IDLE cycle.
- `waitrequest` is ignored outside BUS. `readdata` is ignored outside RESP for loads.

## Structure
- Shared package `mips_cpu_pkg`: `lsu_size_t` (BYTE/HALF/WORD/ILLEGAL) and `lsu_state_t` (IDLE/BUS/RESP). The pkg already owns opcode/function typedefs.
- Sub-module `mips_cpu_lsu_lane`: combinational logic computing `byteenable`, `writedata` replication, load lane extraction/extension and the misalignment flag from size, addr[1:0] and signed. Reused by the verification reference model.

## Test plan
- Load byte, signed, addr 0x1003, no wait: `readdata`=0x80AB_CDEF → `byteenable`=1000, `address`=0x1000, `resp_rdata`=0xFFFF_FF80, resp in cycle 2.
- Load half, unsigned, addr 0x2002, 3 wait cycles: `readdata`=0xBEEF_0000 → `byteenable`=1100, `read` held 4 cycles, `resp_rdata`=0x0000_BEEF.
- Store byte, addr 0x3001, wdata 0x0000_00A5 → `write`=1, `byteenable`=0010, `writedata`=0xA5A5_A5A5, `resp_rdata`=0.
- Store word, addr 0x4002 (misaligned) → no `read`/`write` ever, `resp_valid`+`resp_err` in cycle 1.
- WAIT_LIMIT=4, load word with `waitrequest` stuck at 1 → `read` high 4 cycles, then drops, `resp_err`=1.
- Reset asserted during BUS with waitrequest=1 → `read`=0 next cycle, no `resp_valid`, `req_ready`=1 the cycle after reset deasserts.
